cp0_regs: RTL and testbench



---
 rtl/cp0_regs.sv | 162 ++++++++++++++++
 tb/tb_cp0_regs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC plus interrupt merge.
// Define CP0_TIMER_EN to build the Count/Compare timer; without it Count/Compare read 0 and TI is 0.
module cp0_regs (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  hw_intr,
   input  logic        wt_en,
   input  logic [4:0]  wt_addr,
   input  logic [31:0] wt_data,
   input  logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   input  logic        cp0_en,
   input  logic        cp0_bd,
   input  logic        cp0_exl,
   input  logic [4:0]  cp0_exc,
   input  logic [31:0] cp0_epc,
   input  logic [31:0] cp0_bva,
   input  logic        er,
   output logic [7:0]  intr_vect,
   output logic [31:0] er_epc,
   output logic        status_exl
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   logic [31:0] badvaddr;
   logic [31:0] epc;
   logic [7:0]  status_im;
   logic        status_exl_q;
   logic        status_ie;
   logic        cause_bd;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exc;
   logic [5:0]  hw_intr_q;

   logic [31:0] count;
   logic [31:0] compare;
   logic        cause_ti;

   logic [7:0]  cause_ip;
   logic [31:0] status_word;
   logic [31:0] cause_word;

   // An MTC0 colliding with an exception commit belongs to a killed instruction.
   logic wt_act;
   assign wt_act = wt_en & ~cp0_en;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         badvaddr     <= '0;
         epc          <= '0;
         status_im    <= '0;
         status_exl_q <= 1'b0;
         status_ie    <= 1'b0;
         cause_bd     <= 1'b0;
         cause_ip_sw  <= '0;
         cause_exc    <= '0;
         hw_intr_q    <= '0;
      end else begin
         hw_intr_q <= hw_intr;
         if (cp0_en) begin
            cause_exc <= cp0_exc;
            if (!status_exl_q) begin
               epc      <= cp0_epc;
               cause_bd <= cp0_bd;
            end
            if (cp0_exl)
               status_exl_q <= 1'b1;
            if (cp0_exc == EXC_ADEL || cp0_exc == EXC_ADES)
               badvaddr <= cp0_bva;
         end else begin
            if (er)
               status_exl_q <= 1'b0;
            if (wt_en) begin
               case (wt_addr)
                  REG_STATUS: begin
                     status_im    <= wt_data[15:8];
                     status_exl_q <= wt_data[1];
                     status_ie    <= wt_data[0];
                  end
                  REG_CAUSE: cause_ip_sw <= wt_data[9:8];
                  REG_EPC:   epc         <= wt_data;
                  default:   ;
               endcase
            end
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic        tick;
   logic [31:0] count_nxt;
   logic        count_wr;
   logic        compare_wr;

   assign count_wr   = wt_act && (wt_addr == REG_COUNT);
   assign compare_wr = wt_act && (wt_addr == REG_COMPARE);

   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_nxt = count;
      if (count_wr)
         count_nxt = wt_data;
      else if (tick)
         count_nxt = count + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick     <= 1'b0;
         count    <= '0;
         compare  <= '0;
         cause_ti <= 1'b0;
      end else begin
         tick  <= count_wr ? 1'b0 : ~tick;
         count <= count_nxt;
         if (compare_wr)
            compare <= wt_data;
         // Compare write acknowledges the timer and beats a coincident match.
         if (compare_wr)
            cause_ti <= 1'b0;
         else if (count_nxt == compare && compare != 32'd0)
            cause_ti <= 1'b1;
      end
   end
`else
   assign count    = '0;
   assign compare  = '0;
   assign cause_ti = 1'b0;
`endif

   assign cause_ip    = {hw_intr_q[5] | cause_ti, hw_intr_q[4:0], cause_ip_sw};
   assign status_word = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl_q, status_ie};
   assign cause_word  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         REG_BADVADDR: rd_data = badvaddr;
         REG_COUNT:    rd_data = count;
         REG_COMPARE:  rd_data = compare;
         REG_STATUS:   rd_data = status_word;
         REG_CAUSE:    rd_data = cause_word;
         REG_EPC:      rd_data = epc;
         default:      rd_data = '0;
      endcase
   end

   assign intr_vect  = (status_ie && !status_exl_q) ? (cause_ip & status_im) : 8'h00;
   assign er_epc     = epc;
   assign status_exl = status_exl_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed self-checking bench for cp0_regs; timer checks follow CP0_TIMER_EN.
module tb_cp0_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  hw_intr;
   logic        wt_en;
   logic [4:0]  wt_addr;
   logic [31:0] wt_data;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        cp0_en;
   logic        cp0_bd;
   logic        cp0_exl;
   logic [4:0]  cp0_exc;
   logic [31:0] cp0_epc;
   logic [31:0] cp0_bva;
   logic        er;
   logic [7:0]  intr_vect;
   logic [31:0] er_epc;
   logic        status_exl;

   int n_cmp = 0;
   int n_err = 0;

   cp0_regs dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hw_intr    (hw_intr),
      .wt_en      (wt_en),
      .wt_addr    (wt_addr),
      .wt_data    (wt_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .cp0_en     (cp0_en),
      .cp0_bd     (cp0_bd),
      .cp0_exl    (cp0_exl),
      .cp0_exc    (cp0_exc),
      .cp0_epc    (cp0_epc),
      .cp0_bva    (cp0_bva),
      .er         (er),
      .intr_vect  (intr_vect),
      .er_epc     (er_epc),
      .status_exl (status_exl)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      wt_en   = 1'b1;
      wt_addr = addr;
      wt_data = data;
      step();
      wt_en   = 1'b0;
   endtask

   task automatic mfc0(input logic [4:0] addr, output logic [31:0] data);
      rd_addr = addr;
      #1;
      data = rd_data;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (intr_vect !== 8'h00 || er_epc !== 32'h0 || status_exl !== 1'b0) begin
         $display("FAIL reset_outputs got iv=%h epc=%h exl=%b want 00/0/0", intr_vect, er_epc, status_exl);
         n_err++;
      end
      #9 rst_n = 1'b1;
      mfc0(5'd12, v);
      n_cmp++;
      if (v !== 32'h0040_0000) begin $display("FAIL reset_status got %h want 00400000", v); n_err++; end
      mfc0(5'd8, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL reset_badvaddr got %h want 0", v); n_err++; end
      mfc0(5'd9, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL reset_count got %h want 0", v); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL reset_cause got %h want 0", v); n_err++; end
      mfc0(5'd14, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL reset_epc got %h want 0", v); n_err++; end
      step();
   endtask

   task automatic test_regmap();
      logic [31:0] v;
      mtc0(5'd12, 32'hFFFF_FFFF);
      mfc0(5'd12, v);
      n_cmp++;
      if (v !== 32'h0040_FF03) begin $display("FAIL status_mask got %h want 0040ff03", v); n_err++; end
      mtc0(5'd12, 32'h0);
      mtc0(5'd3, 32'hDEAD_BEEF);
      mfc0(5'd3, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL unmapped got %h want 0", v); n_err++; end
      mtc0(5'd8, 32'h1111_2222);
      mfc0(5'd8, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL badvaddr_ro got %h want 0", v); n_err++; end
      // Same-cycle read of the register being written returns the old value.
      wt_en = 1'b1; wt_addr = 5'd14; wt_data = 32'hCAFE_0004;
      mfc0(5'd14, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL no_bypass got %h want 0", v); n_err++; end
      step();
      wt_en = 1'b0;
      mfc0(5'd14, v);
      n_cmp++;
      if (v !== 32'hCAFE_0004) begin $display("FAIL epc_write got %h want cafe0004", v); n_err++; end
   endtask

   task automatic test_exception();
      logic [31:0] v;
      cp0_en = 1'b1; cp0_exc = 5'h04; cp0_epc = 32'hBFC0_0100; cp0_bd = 1'b1;
      cp0_bva = 32'h0000_0003; cp0_exl = 1'b1;
      step();
      cp0_en = 1'b0; cp0_exl = 1'b0;
      n_cmp++;
      if (er_epc !== 32'hBFC0_0100) begin $display("FAIL exc_epc got %h want bfc00100", er_epc); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if (v !== 32'h8000_0010) begin $display("FAIL exc_cause got %h want 80000010", v); n_err++; end
      mfc0(5'd8, v);
      n_cmp++;
      if (v !== 32'h0000_0003) begin $display("FAIL exc_badvaddr got %h want 3", v); n_err++; end
      n_cmp++;
      if (status_exl !== 1'b1) begin $display("FAIL exc_exl got %b want 1", status_exl); n_err++; end
      // Nested exception: EPC/BD/BadVAddr hold, ExcCode updates.
      cp0_en = 1'b1; cp0_exc = 5'h0C; cp0_epc = 32'h0000_1234; cp0_bd = 1'b0;
      cp0_bva = 32'h5555_0000; cp0_exl = 1'b1;
      step();
      cp0_en = 1'b0; cp0_exl = 1'b0;
      n_cmp++;
      if (er_epc !== 32'hBFC0_0100) begin $display("FAIL nested_epc got %h want bfc00100", er_epc); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if (v !== 32'h8000_0030) begin $display("FAIL nested_cause got %h want 80000030", v); n_err++; end
      mfc0(5'd8, v);
      n_cmp++;
      if (v !== 32'h0000_0003) begin $display("FAIL nested_badvaddr got %h want 3", v); n_err++; end
   endtask

   task automatic test_interrupts();
      er = 1'b1;
      step();
      er = 1'b0;
      n_cmp++;
      if (status_exl !== 1'b0) begin $display("FAIL eret_exl got %b want 0", status_exl); n_err++; end
      mtc0(5'd12, 32'h0000_0401);
      mtc0(5'd13, 32'h0000_0100);
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL ip0_masked got %h want 00", intr_vect); n_err++; end
      mtc0(5'd12, 32'h0000_0101);
      n_cmp++;
      if (intr_vect !== 8'h01) begin $display("FAIL ip0_enabled got %h want 01", intr_vect); n_err++; end
      cp0_en = 1'b1; cp0_exl = 1'b1; cp0_exc = 5'h00; cp0_epc = 32'h0000_0400; cp0_bd = 1'b0;
      step();
      cp0_en = 1'b0; cp0_exl = 1'b0;
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL exl_blocks got %h want 00", intr_vect); n_err++; end
      er = 1'b1;
      step();
      er = 1'b0;
      n_cmp++;
      if (intr_vect !== 8'h01) begin $display("FAIL eret_restores got %h want 01", intr_vect); n_err++; end
   endtask

   task automatic test_eret_collision();
      er = 1'b1; cp0_en = 1'b1; cp0_exl = 1'b1; cp0_exc = 5'h00; cp0_epc = 32'h0000_2000;
      wt_en = 1'b1; wt_addr = 5'd14; wt_data = 32'hAAAA_AAAA;
      step();
      er = 1'b0; cp0_en = 1'b0; cp0_exl = 1'b0; wt_en = 1'b0;
      n_cmp++;
      if (status_exl !== 1'b1) begin $display("FAIL collide_exl got %b want 1", status_exl); n_err++; end
      n_cmp++;
      if (er_epc !== 32'h0000_2000) begin $display("FAIL collide_epc got %h want 00002000", er_epc); n_err++; end
      er = 1'b1;
      step();
      er = 1'b0;
      mtc0(5'd13, 32'h0);
   endtask

   task automatic test_hw_intr();
      logic [31:0] v;
      mtc0(5'd12, 32'h0000_0401);
      hw_intr = 6'b000001;
      #1;
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL hw_lag got %h want 00", intr_vect); n_err++; end
      step();
      n_cmp++;
      if (intr_vect !== 8'h04) begin $display("FAIL hw_ip2 got %h want 04", intr_vect); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if ((v & 32'h0000_0400) !== 32'h0000_0400) begin $display("FAIL hw_cause_bit10 got %h want bit10 set", v); n_err++; end
      hw_intr = 6'b000000;
      step();
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL hw_drop got %h want 00", intr_vect); n_err++; end
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      logic [31:0] v;
      bit seen;
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      mfc0(5'd9, v);
      n_cmp++;
      if (v !== 32'd0) begin $display("FAIL count_load got %h want 0", v); n_err++; end
      mtc0(5'd12, 32'h0000_8001);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (intr_vect == 8'h80) seen = 1'b1;
         else step();
      end
      n_cmp++;
      if (!seen) begin $display("FAIL timer_irq got %h want 80 (timeout)", intr_vect); n_err++; end
      mfc0(5'd9, v);
      n_cmp++;
      if (v !== 32'd5) begin $display("FAIL timer_count got %h want 5", v); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if (v[30] !== 1'b1) begin $display("FAIL timer_ti got %h want bit30 set", v); n_err++; end
      mtc0(5'd11, 32'd5);
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL ti_clear_iv got %h want 00", intr_vect); n_err++; end
      mfc0(5'd13, v);
      n_cmp++;
      if (v[30] !== 1'b0) begin $display("FAIL ti_clear got %h want bit30 clear", v); n_err++; end
      mtc0(5'd9, 32'hFFFF_FFFF);
      step();
      step();
      mfc0(5'd9, v);
      n_cmp++;
      if (v !== 32'd0) begin $display("FAIL count_wrap got %h want 0", v); n_err++; end
      mtc0(5'd11, 32'd0);
   endtask
`else
   task automatic test_timer();
      logic [31:0] v;
      mtc0(5'd9, 32'h0000_1234);
      mtc0(5'd11, 32'h0000_0005);
      mfc0(5'd9, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL count_off got %h want 0", v); n_err++; end
      mfc0(5'd11, v);
      n_cmp++;
      if (v !== 32'h0) begin $display("FAIL compare_off got %h want 0", v); n_err++; end
      mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 20; i++) step();
      n_cmp++;
      if (intr_vect !== 8'h00) begin $display("FAIL ti_off got %h want 00", intr_vect); n_err++; end
   endtask
`endif

   initial begin
      rst_n = 1'b0; hw_intr = '0; wt_en = 1'b0; wt_addr = '0; wt_data = '0; rd_addr = '0;
      cp0_en = 1'b0; cp0_bd = 1'b0; cp0_exl = 1'b0; cp0_exc = '0; cp0_epc = '0; cp0_bva = '0;
      er = 1'b0;
      test_reset();
      test_regmap();
      test_exception();
      test_interrupts();
      test_eret_collision();
      test_hw_intr();
      test_timer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
